// File: rtl/spi_frame_decoder_if.sv
// SPI frame decoder bus: SPI pins from the master plus the decoded
// write/read/error outputs. The slave modport is the decoder side;
// the master modport is the stimulus/consumer side.
interface spi_frame_decoder_if;
  logic        spi_sclk;
  logic        spi_sdo;
  logic        spi_cs;
  logic        spi_sdi;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic        frame_err;

  modport slave (
    input  spi_sclk, spi_sdo, spi_cs,
    output spi_sdi, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, frame_err
  );

  modport master (
    output spi_sclk, spi_sdo, spi_cs,
    input  spi_sdi, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, frame_err
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// SPI frame decoder. Oversamples spi_sclk in the clk_i domain and decodes
// frames of the form CMD(8) ADDR(32) [DUMMY(34)] DATA(32), MSB first.
//   cmd 0x02 : write frame -> wr_valid / wr_addr / wr_data
//   cmd 0x0B : read frame  -> rd_valid / rd_addr
// Optional feature macro: SPI_DEC_READBACK_EN adds a 16x32 word store that
// is written by write frames and shifted out on spi_sdi during read frames.
module spi_frame_decoder #(
  parameter int ADDR_LSB = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  spi_frame_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ERR} state_t;

  // The 4-bit word index must lie inside the 32-bit address.
  if (ADDR_LSB < 0 || ADDR_LSB > 28) begin : g_bad_addr_lsb
    $error("ADDR_LSB must be in 0..28");
  end

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_sclk;
  logic        r_armed;
  logic        r_started;
  logic        r_is_rd;
  logic [6:0]  r_cmd;
  logic [31:0] r_addr;
  logic [30:0] r_data;
  logic        r_wr_valid;
  logic        r_rd_valid;
  logic        r_frame_err;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_addr;

  logic        w_bit;
  logic [7:0]  w_cmd_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_data_nxt;

  // A bit event is a rising spi_sclk seen while the chip is selected.
  assign w_bit      = !bus.spi_cs && bus.spi_sclk && !r_sclk;
  assign w_cmd_nxt  = {r_cmd, bus.spi_sdo};
  assign w_addr_nxt = {r_addr[30:0], bus.spi_sdo};
  assign w_data_nxt = {r_data, bus.spi_sdo};

  // Frame state machine, bit counter, shift registers and output pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= 6'd0;
      r_sclk      <= 1'b0;
      r_armed     <= 1'b0;
      r_started   <= 1'b0;
      r_is_rd     <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= 32'd0;
      r_wr_data   <= 32'd0;
      r_rd_addr   <= 32'd0;
    end else begin
      r_sclk      <= bus.spi_sclk;
      // Decoding is held off until CS has been seen idle once after reset.
      r_armed     <= r_armed | bus.spi_cs;
      r_wr_valid  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_armed && !bus.spi_cs) begin
            r_state   <= CMD;
            r_cnt     <= 6'd7;
            r_started <= 1'b0;
          end
        end
        CMD: begin
          if (bus.spi_cs) begin
            // Only a frame that already shifted a bit counts as aborted.
            r_state     <= IDLE;
            r_frame_err <= r_started;
          end else if (w_bit) begin
            r_cmd     <= w_cmd_nxt[6:0];
            r_started <= 1'b1;
            if (r_cnt == 6'd0) begin
              if (w_cmd_nxt == 8'h02 || w_cmd_nxt == 8'h0B) begin
                r_state <= ADDR;
                r_cnt   <= 6'd31;
                r_is_rd <= (w_cmd_nxt == 8'h0B);
              end else begin
                r_state     <= ERR;
                r_frame_err <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        ADDR: begin
          if (bus.spi_cs) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else if (w_bit) begin
            r_addr <= w_addr_nxt;
            if (r_cnt == 6'd0) begin
              r_state <= r_is_rd ? DUMMY : DATA;
              r_cnt   <= r_is_rd ? 6'd33 : 6'd31;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        DUMMY: begin
          if (bus.spi_cs) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else if (w_bit) begin
            if (r_cnt == 6'd0) begin
              r_state <= DATA;
              r_cnt   <= 6'd31;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        DATA: begin
          // CS high always wins, so a deassert with the final bit is an abort.
          if (bus.spi_cs) begin
            r_state     <= IDLE;
            r_frame_err <= 1'b1;
          end else if (w_bit) begin
            r_data <= w_data_nxt[30:0];
            if (r_cnt == 6'd0) begin
              if (r_is_rd) begin
                r_rd_valid <= 1'b1;
                r_rd_addr  <= r_addr;
              end else begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_data_nxt;
              end
              r_state   <= CMD;
              r_cnt     <= 6'd7;
              r_started <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 6'd1;
            end
          end
        end
        ERR: begin
          if (bus.spi_cs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.frame_err = r_frame_err;

`ifdef SPI_DEC_READBACK_EN
  logic [31:0] r_mem [16];
  logic [31:0] r_sr;
  logic        r_sdi;
  logic        w_wr_done;
  logic        w_dummy_last;
  logic        w_data_bit;
  logic [3:0]  w_idx;

  assign w_idx        = r_addr[ADDR_LSB+3:ADDR_LSB];
  assign w_wr_done    = (r_state == DATA) && !bus.spi_cs && w_bit &&
                        (r_cnt == 6'd0) && !r_is_rd;
  assign w_dummy_last = (r_state == DUMMY) && w_bit && (r_cnt == 6'd0);
  assign w_data_bit   = (r_state == DATA) && w_bit;

  // Word store, written with the data of each completed write frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= 32'd0;
    end else if (w_wr_done) begin
      r_mem[w_idx] <= w_data_nxt;
    end
  end

  // Readback shifter: loads on the last dummy bit, advances per data bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sr  <= 32'd0;
      r_sdi <= 1'b0;
    end else if (w_dummy_last) begin
      r_sr  <= r_mem[w_idx];
      r_sdi <= r_mem[w_idx][31];
    end else if (w_data_bit) begin
      r_sr  <= {r_sr[30:0], 1'b0};
      r_sdi <= r_sr[30];
    end else if (r_state == IDLE) begin
      r_sdi <= 1'b0;
    end
  end

  assign bus.spi_sdi = r_sdi;
`else
  assign bus.spi_sdi = 1'b0;
`endif

endmodule

// File: doc/spi_frame_decoder.md
SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 The block SHALL have the following parameter: ADDR_LSB, default 2, meaning the bit position of the word-index LSB within the 32-bit address.
REQ-002 The block SHALL have the following ports:
- clk_i, input, 1, single clock, same domain as the SPI stimulus generator.
- rst_ni, input, 1, reset, synchronous and active-low.
- spi_sclk, input, 1, SPI clock from the master, toggling at most every clk_i cycle.
- spi_sdo, input, 1, master data out, MSB first.
- spi_cs, input, 1, chip select, active-low.
- spi_sdi, output, 1, read data returned to the master.
- wr_valid, output, 1, one-cycle pulse marking a completed write frame.
- wr_addr, output, 32, address of the last write frame.
- wr_data, output, 32, data of the last write frame.
- rd_valid, output, 1, one-cycle pulse marking a completed read frame.
- rd_addr, output, 32, address of the last read frame.
- frame_err, output, 1, one-cycle pulse on an unknown command or an aborted frame.

Function
REQ-003 The block SHALL treat a bit event as a clk_i edge where spi_cs=0, spi_sclk=1, and the spi_sclk value registered in the previous cycle was 0; spi_sdo SHALL be sampled at that edge.
REQ-004 The state machine SHALL have the states IDLE, CMD, ADDR, DUMMY, DATA and ERR, with a 6-bit down-counter for bits remaining.
REQ-005 IDLE -> CMD SHALL occur when spi_cs=0; the counter SHALL be loaded with 7.
REQ-006 CMD SHALL shift 8 bits MSB first; after the 8th bit:
- cmd 0x02 -> ADDR.
- cmd 0x0B -> ADDR.
- any other cmd -> ERR, with frame_err pulsed.
REQ-007 ADDR SHALL shift 32 bits MSB first; after the 32nd bit:
- a write frame -> DATA (32 bits).
- a read frame -> DUMMY (34 bits).
REQ-008 DUMMY SHALL ignore spi_sdo for 34 bit events, then enter DATA (32 bits).
REQ-009 On completion of a write frame's DATA phase, the block SHALL:
- register wr_addr and wr_data;
- pulse wr_valid for exactly 1 cycle, in the cycle after the last bit event.
REQ-010 On completion of a read frame's DATA phase, the block SHALL register rd_addr and pulse rd_valid for exactly 1 cycle, in the cycle after the last bit event.
REQ-011 After DATA completes with spi_cs still 0, the block SHALL enter CMD directly; back-to-back frames without a CS toggle SHALL be supported.
REQ-012 ERR SHALL ignore all bit events until spi_cs=1, then enter IDLE.
REQ-013 spi_cs=1 in CMD, ADDR, DUMMY or DATA with at least one bit of that frame already shifted SHALL:
- pulse frame_err;
- enter IDLE;
- suppress wr_valid and rd_valid for that frame.
REQ-014 spi_cs=1 in CMD before any bit event SHALL enter IDLE without pulsing frame_err.
REQ-015 A spi_cs deassert in the same cycle as the final DATA bit event SHALL count as an abort, not a completion.
REQ-016 wr_addr, wr_data and rd_addr SHALL hold their values until the next completed frame of the same type.
REQ-017 The bit counter SHALL never wrap; a bit event with counter 0 SHALL perform the phase transition and load the next phase's counter.

Reset
REQ-018 While rst_ni=0 at a clk_i edge, the block SHALL set:
- state to IDLE and the counter to 0;
- spi_sdi, wr_valid, rd_valid and frame_err to 0;
- wr_addr, wr_data and rd_addr to 0;
- the registered spi_sclk to 0.
REQ-019 A reset mid-frame SHALL discard the frame with no valid or error pulse.
REQ-020 Decoding after reset release SHALL begin only once spi_cs has been observed as 1 at least once.

Configuration
REQ-021 With SPI_DEC_READBACK_EN defined, the block SHALL contain a 16x32 word store indexed by addr[ADDR_LSB+3:ADDR_LSB], which behaves as follows:
- It is written on wr_valid.
- For read frames, the addressed word is loaded into a shift register on the last DUMMY bit event.
- spi_sdi presents the word MSB first: the MSB is driven in the cycle after that load.
- Each subsequent bit is driven in the cycle after each DATA bit event.
REQ-022 With SPI_DEC_READBACK_EN defined, the word store SHALL reset to all zeros.
REQ-023 Without SPI_DEC_READBACK_EN, the block SHALL have no word store; spi_sdi SHALL be constant 0; all other behaviour SHALL be unchanged.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Write: cmd 0x02, addr 100, data 100, CS held low -> one wr_valid pulse with wr_addr=100, wr_data=100; frame_err=0.
- Back-to-back write then read: cmd 0x02/addr 100/data 100, then cmd 0x0B/addr 100 with 34 dummy bits and 32 data bits, no CS toggle -> wr_valid, then rd_valid with rd_addr=100; with SPI_DEC_READBACK_EN, spi_sdi shifts out 0x00000064 MSB first.
- Unknown command: cmd 0x05 followed by 40 bits -> frame_err pulses once after the 8th bit; no wr_valid or rd_valid; IDLE after CS goes high.
- Abort: CS raised after 20 ADDR bits of a write -> frame_err pulse, no wr_valid, wr_addr unchanged.
- Reset mid-DATA: rst_ni=0 for 1 cycle during DATA -> all outputs 0; no pulses; the next full write frame decodes correctly.
- Build without SPI_DEC_READBACK_EN: the read frame of the back-to-back scenario -> spi_sdi stays 0 and rd_valid still pulses with rd_addr=100.
